// File: rtl/cv32e40p_cg_ctrl.sv
// Core clock-gate controller: BOOT/RUN/DRAIN/SLEEP/WAKE sequencing
// that produces a registered enable for the downstream clock gate.
module cv32e40p_cg_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        sleep_req_i,
  input  logic        wake_i,
  input  logic        busy_i,
  output logic        clock_en_o,
  output logic        core_sleep_o,
  output logic        wake_ack_o,
  output logic [15:0] sleep_cnt_o
);

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    DRAIN,
    SLEEP,
    WAKE
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] idle_q;
  logic [7:0] idle_d;
  logic [7:0] wake_q;
  logic [7:0] wake_d;
  logic       ack_d;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    ack_d   = 1'b0;
    unique case (state_q)
      BOOT: begin
        if (fetch_enable_i) state_d = RUN;
      end
      RUN: begin
        if (sleep_req_i && !wake_i) begin
          state_d = DRAIN;
          idle_d  = 8'd0;
        end
      end
      DRAIN: begin
        // Abort beats everything; busy restarts the idle window
        if (wake_i || !sleep_req_i) begin
          state_d = RUN;
        end else if (busy_i) begin
          idle_d = 8'd0;
        end else if (idle_q == IDLE_LAST) begin
          state_d = SLEEP;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      SLEEP: begin
        if (wake_i) begin
          state_d = WAKE;
          wake_d  = 8'd0;
        end
      end
      WAKE: begin
        if (wake_q == WAKE_LAST) begin
          state_d = RUN;
          ack_d   = 1'b1;
        end else begin
          wake_d = wake_q + 8'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT;
      idle_q       <= 8'd0;
      wake_q       <= 8'd0;
      clock_en_o   <= 1'b0;
      core_sleep_o <= 1'b0;
      wake_ack_o   <= 1'b0;
      sleep_cnt_o  <= 16'd0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      wake_q       <= wake_d;
      clock_en_o   <= state_d inside {RUN, DRAIN, WAKE};
      core_sleep_o <= (state_d == SLEEP);
      wake_ack_o   <= ack_d;
      if (core_sleep_o && (sleep_cnt_o != 16'hFFFF))
        sleep_cnt_o <= sleep_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_cg_ctrl.sv
// Directed bench for cv32e40p_cg_ctrl with default parameters.
module tb_cv32e40p_cg_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_enable_i = 1'b0;
  logic        sleep_req_i = 1'b0;
  logic        wake_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        clock_en_o;
  logic        core_sleep_o;
  logic        wake_ack_o;
  logic [15:0] sleep_cnt_o;

  int total = 0;
  int bad = 0;

  cv32e40p_cg_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fetch_enable_i (fetch_enable_i),
    .sleep_req_i    (sleep_req_i),
    .wake_i         (wake_i),
    .busy_i         (busy_i),
    .clock_en_o     (clock_en_o),
    .core_sleep_o   (core_sleep_o),
    .wake_ack_o     (wake_ack_o),
    .sleep_cnt_o    (sleep_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    step();
    total++; if (clock_en_o !== 1'b0) begin bad++; $display("FAIL rst_en got=%0b exp=0", clock_en_o); end
    total++; if (core_sleep_o !== 1'b0) begin bad++; $display("FAIL rst_sleep got=%0b exp=0", core_sleep_o); end
    total++; if (wake_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%0b exp=0", wake_ack_o); end
    total++; if (sleep_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", sleep_cnt_o); end
  endtask

  task automatic test_boot();
    fetch_enable_i = 1'b0;
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (clock_en_o !== 1'b0) begin bad++; $display("FAIL boot_hold%0d got=%0b exp=0", i, clock_en_o); end
    end
    fetch_enable_i = 1'b1;
    step();
    total++; if (clock_en_o !== 1'b1) begin bad++; $display("FAIL boot_run got=%0b exp=1", clock_en_o); end
    total++; if (core_sleep_o !== 1'b0) begin bad++; $display("FAIL boot_sleep got=%0b exp=0", core_sleep_o); end
  endtask

  task automatic test_clean_sleep();
    sleep_req_i = 1'b1;
    busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (clock_en_o !== 1'b1 || core_sleep_o !== 1'b0) begin bad++; $display("FAIL drain%0d got=%0b%0b exp=10", i, clock_en_o, core_sleep_o); end
    end
    step();
    total++; if (clock_en_o !== 1'b0) begin bad++; $display("FAIL sleep_en got=%0b exp=0", clock_en_o); end
    total++; if (core_sleep_o !== 1'b1) begin bad++; $display("FAIL sleep_flag got=%0b exp=1", core_sleep_o); end
    total++; if (sleep_cnt_o !== 16'd0) begin bad++; $display("FAIL sleep_cnt0 got=%0d exp=0", sleep_cnt_o); end
    // sleep_req and busy must not disturb SLEEP
    sleep_req_i = 1'b0;
    busy_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    busy_i = 1'b0;
    total++; if (core_sleep_o !== 1'b1) begin bad++; $display("FAIL sleep_hold got=%0b exp=1", core_sleep_o); end
    total++; if (sleep_cnt_o !== 16'd10) begin bad++; $display("FAIL sleep_cnt10 got=%0d exp=10", sleep_cnt_o); end
  endtask

  task automatic test_wake();
    wake_i = 1'b1;
    step();
    wake_i = 1'b0;
    total++; if (clock_en_o !== 1'b1 || core_sleep_o !== 1'b0) begin bad++; $display("FAIL wake1 got=%0b%0b exp=10", clock_en_o, core_sleep_o); end
    total++; if (wake_ack_o !== 1'b0) begin bad++; $display("FAIL wake1_ack got=%0b exp=0", wake_ack_o); end
    total++; if (sleep_cnt_o !== 16'd11) begin bad++; $display("FAIL wake_cnt got=%0d exp=11", sleep_cnt_o); end
    step();
    total++; if (clock_en_o !== 1'b1 || wake_ack_o !== 1'b0) begin bad++; $display("FAIL wake2 got=%0b%0b exp=10", clock_en_o, wake_ack_o); end
    step();
    total++; if (wake_ack_o !== 1'b1 || clock_en_o !== 1'b1) begin bad++; $display("FAIL wake_ack got=%0b%0b exp=11", wake_ack_o, clock_en_o); end
    step();
    total++; if (wake_ack_o !== 1'b0) begin bad++; $display("FAIL ack_pulse got=%0b exp=0", wake_ack_o); end
    total++; if (sleep_cnt_o !== 16'd11) begin bad++; $display("FAIL cnt_keep got=%0d exp=11", sleep_cnt_o); end
  endtask

  task automatic test_busy_restart();
    sleep_req_i = 1'b1;
    step();
    step();
    busy_i = 1'b1;
    step();
    busy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (clock_en_o !== 1'b1 || core_sleep_o !== 1'b0) begin bad++; $display("FAIL busy_drain%0d got=%0b%0b exp=10", i, clock_en_o, core_sleep_o); end
    end
    step();
    total++; if (core_sleep_o !== 1'b1 || clock_en_o !== 1'b0) begin bad++; $display("FAIL busy_sleep got=%0b%0b exp=10", core_sleep_o, clock_en_o); end
    sleep_req_i = 1'b0;
    wake_i = 1'b1;
    step();
    wake_i = 1'b0;
    step();
    step();
    total++; if (wake_ack_o !== 1'b1) begin bad++; $display("FAIL busy_wake_ack got=%0b exp=1", wake_ack_o); end
  endtask

  task automatic test_abort();
    int sleeps;
    sleeps = 0;
    fetch_enable_i = 1'b0;
    sleep_req_i = 1'b1;
    step();
    wake_i = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      if (core_sleep_o) sleeps++;
      total++; if (clock_en_o !== 1'b1) begin bad++; $display("FAIL abort_en%0d got=%0b exp=1", i, clock_en_o); end
    end
    total++; if (sleeps !== 0) begin bad++; $display("FAIL abort_nosleep got=%0d exp=0", sleeps); end
    wake_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++; if (core_sleep_o !== 1'b0) begin bad++; $display("FAIL abort_early got=%0b exp=0", core_sleep_o); end
    step();
    total++; if (core_sleep_o !== 1'b1) begin bad++; $display("FAIL abort_resleep got=%0b exp=1", core_sleep_o); end
  endtask

  task automatic test_reset_mid_wake();
    sleep_req_i = 1'b0;
    wake_i = 1'b1;
    step();
    wake_i = 1'b0;
    total++; if (clock_en_o !== 1'b1) begin bad++; $display("FAIL mw_wake got=%0b exp=1", clock_en_o); end
    rst_ni = 1'b0;
    #1;
    total++; if (clock_en_o !== 1'b0) begin bad++; $display("FAIL mw_en got=%0b exp=0", clock_en_o); end
    total++; if (sleep_cnt_o !== 16'd0) begin bad++; $display("FAIL mw_cnt got=%0d exp=0", sleep_cnt_o); end
    step();
    step();
    total++; if (wake_ack_o !== 1'b0) begin bad++; $display("FAIL mw_ack got=%0b exp=0", wake_ack_o); end
    rst_ni = 1'b1;
    fetch_enable_i = 1'b0;
    step();
    step();
    total++; if (clock_en_o !== 1'b0 || wake_ack_o !== 1'b0) begin bad++; $display("FAIL mw_boot got=%0b%0b exp=00", clock_en_o, wake_ack_o); end
    fetch_enable_i = 1'b1;
    step();
    total++; if (clock_en_o !== 1'b1) begin bad++; $display("FAIL mw_rerun got=%0b exp=1", clock_en_o); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_clean_sleep();
    test_wake();
    test_busy_restart();
    test_abort();
    test_reset_mid_wake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk_i) begin
    if (rst_ni && clock_en_o && core_sleep_o) begin
      total++;
      bad++;
      $display("FAIL excl got=11 exp=not both");
    end
  end

endmodule
